shift_add_mult: RTL and testbench

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

---
 rtl/shift_add_mult_pkg.sv | 15 +
 rtl/shift_add_mult_dp.sv | 52 +++++
 rtl/shift_add_mult.sv | 88 ++++++++
 tb/tb_shift_add_mult.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_add_mult_pkg.sv
// Shared types and helpers for the shift-and-add multiplier.
package shift_add_mult_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   // Width of the bit counter P, which must hold DP_WIDTH down to 0.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/shift_add_mult_dp.sv
// Datapath: A/B/Q/C/P registers with the conditional adder and the {C,A,Q} shifter.
module shift_add_mult_dp
   import shift_add_mult_pkg::*;
#(
   parameter int unsigned DP_WIDTH = 5,
   localparam int unsigned PW = cnt_width(DP_WIDTH)
) (
   input  logic                clock,
   input  logic                reset_b,
   input  logic                load,
   input  logic                step,
   input  logic [DP_WIDTH-1:0] b_load,
   input  logic [DP_WIDTH-1:0] q_load,
   output logic [DP_WIDTH-1:0] a,
   output logic [DP_WIDTH-1:0] q,
   output logic [PW-1:0]       p
);

   logic [DP_WIDTH-1:0] b;
   logic                c;
   logic [DP_WIDTH:0]   sum;

   // {C,A} = A + B when Q[0] is set; the shift below takes the carry into A's MSB.
   always_comb begin
      sum = {c, a};
      if (q[0]) begin
         sum = {c, a} + {1'b0, b};
      end
   end

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         a <= '0;
         b <= '0;
         q <= '0;
         c <= 1'b0;
         p <= '0;
      end else if (load) begin
         a <= '0;
         b <= b_load;
         q <= q_load;
         c <= 1'b0;
         p <= PW'(DP_WIDTH);
      end else if (step) begin
         c <= 1'b0;
         a <= sum[DP_WIDTH:1];
         q <= {sum[0], q[DP_WIDTH-1:1]};
         p <= p - 1'b1;
      end
   end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier, unsigned or two's complement, fixed latency.
module shift_add_mult
   import shift_add_mult_pkg::*;
#(
   parameter int unsigned DP_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  reset_b,
   input  logic                  start,
   input  logic                  signed_mode,
   input  logic [DP_WIDTH-1:0]   multiplicand,
   input  logic [DP_WIDTH-1:0]   multiplier,
   output logic                  busy,
   output logic                  done,
   output logic [2*DP_WIDTH-1:0] product
);

   localparam int unsigned PW = cnt_width(DP_WIDTH);

   state_t                state;
   logic                  sign;
   logic                  load;
   logic                  step;
   logic [DP_WIDTH-1:0]   b_mag;
   logic [DP_WIDTH-1:0]   q_mag;
   logic [DP_WIDTH-1:0]   a;
   logic [DP_WIDTH-1:0]   q;
   logic [PW-1:0]         p;
   logic [2*DP_WIDTH-1:0] aq;

   // Negating the most negative value yields 2^(DP_WIDTH-1), which fits as unsigned.
   always_comb begin
      b_mag = (signed_mode && multiplicand[DP_WIDTH-1]) ? -multiplicand : multiplicand;
      q_mag = (signed_mode && multiplier[DP_WIDTH-1]) ? -multiplier : multiplier;
      load  = (state == IDLE) && start;
      step  = (state == RUN);
      aq    = {a, q};
   end

   shift_add_mult_dp #(
      .DP_WIDTH (DP_WIDTH)
   ) u_dp (
      .clock   (clock),
      .reset_b (reset_b),
      .load    (load),
      .step    (step),
      .b_load  (b_mag),
      .q_load  (q_mag),
      .a       (a),
      .q       (q),
      .p       (p)
   );

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         state   <= IDLE;
         sign    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  sign  <= signed_mode & (multiplicand[DP_WIDTH-1] ^ multiplier[DP_WIDTH-1]);
               end
            end
            RUN: begin
               if (p == PW'(1)) begin
                  state <= FINISH;
               end
            end
            FINISH: begin
               // Negating zero gives zero, so no special case is needed.
               product <= sign ? -aq : aq;
               done    <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed self-checking bench for shift_add_mult at DP_WIDTH=5 and DP_WIDTH=8.
module tb_shift_add_mult;

   logic        clock;
   logic        reset_b;
   logic        start;
   logic        signed_mode;
   logic [4:0]  multiplicand;
   logic [4:0]  multiplier;
   logic        busy;
   logic        done;
   logic [9:0]  product;

   logic        start8;
   logic        signed_mode8;
   logic [7:0]  multiplicand8;
   logic [7:0]  multiplier8;
   logic        busy8;
   logic        done8;
   logic [15:0] product8;

   int errors = 0;
   int checks = 0;

   shift_add_mult #(
      .DP_WIDTH (5)
   ) u_dut (
      .clock        (clock),
      .reset_b      (reset_b),
      .start        (start),
      .signed_mode  (signed_mode),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   shift_add_mult #(
      .DP_WIDTH (8)
   ) u_dut8 (
      .clock        (clock),
      .reset_b      (reset_b),
      .start        (start8),
      .signed_mode  (signed_mode8),
      .multiplicand (multiplicand8),
      .multiplier   (multiplier8),
      .busy         (busy8),
      .done         (done8),
      .product      (product8)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Run one multiplication on the 5-bit DUT; lat counts edges from accept to done.
   task automatic do_mult(input logic [4:0] mc, input logic [4:0] mp, input logic sm,
                          output int lat);
      @(negedge clock);
      start        = 1'b1;
      signed_mode  = sm;
      multiplicand = mc;
      multiplier   = mp;
      @(posedge clock);
      #1 start = 1'b0;
      lat = 0;
      while (lat < 40) begin
         @(posedge clock);
         #1 lat++;
         if (done) break;
      end
   endtask

   task automatic do_mult8(input logic [7:0] mc, input logic [7:0] mp, input logic sm,
                           output int lat);
      @(negedge clock);
      start8        = 1'b1;
      signed_mode8  = sm;
      multiplicand8 = mc;
      multiplier8   = mp;
      @(posedge clock);
      #1 start8 = 1'b0;
      lat = 0;
      while (lat < 40) begin
         @(posedge clock);
         #1 lat++;
         if (done8) break;
      end
   endtask

   initial begin
      int lat;
      int n;
      int dones;
      reset_b       = 1'b0;
      start         = 1'b0;
      signed_mode   = 1'b0;
      multiplicand  = '0;
      multiplier    = '0;
      start8        = 1'b0;
      signed_mode8  = 1'b0;
      multiplicand8 = '0;
      multiplier8   = '0;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check("reset_product", 32'(product), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_product8", 32'(product8), 32'd0);
      @(negedge clock) reset_b = 1'b1;

      // Unsigned exhaustive
      for (int i = 0; i < 32; i++) begin
         for (int j = 0; j < 32; j++) begin
            do_mult(5'(i), 5'(j), 1'b0, lat);
            check($sformatf("uns_%0d_x_%0d", i, j), 32'(product), 32'(i * j));
            check($sformatf("uns_lat_%0d_x_%0d", i, j), 32'(lat), 32'd6);
         end
      end

      // Signed corners
      do_mult(5'h10, 5'h10, 1'b1, lat);
      check("sgn_m16_x_m16", 32'(product), 32'h100);
      check("sgn_lat", 32'(lat), 32'd6);
      do_mult(5'h10, 5'h0F, 1'b1, lat);
      check("sgn_m16_x_15", 32'(product), 32'h310);
      do_mult(5'h1F, 5'h00, 1'b1, lat);
      check("sgn_m1_x_0", 32'(product), 32'h000);
      do_mult(5'h07, 5'h1D, 1'b1, lat);
      check("sgn_7_x_m3", 32'(product), 32'h3EB);

      // Start while busy: 9*9 pulsed at cycle 2 must be dropped
      @(negedge clock);
      start        = 1'b1;
      signed_mode  = 1'b0;
      multiplicand = 5'd3;
      multiplier   = 5'd5;
      @(posedge clock);
      #1 start = 1'b0;
      check("busy_after_accept", 32'(busy), 32'd1);
      lat = 0;
      while (lat < 40) begin
         @(posedge clock);
         #1 lat++;
         if (lat == 1) begin
            @(negedge clock);
            start        = 1'b1;
            multiplicand = 5'd9;
            multiplier   = 5'd9;
         end else if (lat == 2) begin
            start = 1'b0;
         end
         if (done) break;
      end
      check("busy_drop_product", 32'(product), 32'd15);
      check("busy_drop_lat", 32'(lat), 32'd6);
      check("busy_low_at_done", 32'(busy), 32'd0);
      dones = 0;
      repeat (12) begin
         @(posedge clock);
         #1 if (done) dones++;
      end
      check("busy_drop_no_extra_done", 32'(dones), 32'd0);

      // Back-to-back with start held high
      @(negedge clock);
      start        = 1'b1;
      signed_mode  = 1'b0;
      multiplicand = 5'd31;
      multiplier   = 5'd31;
      n = 0;
      while (n < 40) begin
         @(posedge clock);
         #1 n++;
         if (done) break;
      end
      check("b2b_first_product", 32'(product), 32'd961);
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (n < 40) begin
            @(posedge clock);
            #1 n++;
            if (done) break;
         end
         check($sformatf("b2b_period_%0d", k), 32'(n), 32'd7);
         check($sformatf("b2b_product_%0d", k), 32'(product), 32'd961);
      end
      @(negedge clock) start = 1'b0;
      repeat (10) @(posedge clock);

      // Reset mid-RUN aborts the operation silently
      @(negedge clock);
      start        = 1'b1;
      multiplicand = 5'd12;
      multiplier   = 5'd11;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock) reset_b = 1'b0;
      #1;
      check("abort_product", 32'(product), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      @(negedge clock) reset_b = 1'b1;
      dones = 0;
      repeat (12) begin
         @(posedge clock);
         #1 if (done) dones++;
      end
      check("abort_no_done", 32'(dones), 32'd0);
      do_mult(5'd2, 5'd3, 1'b0, lat);
      check("after_abort_product", 32'(product), 32'd6);
      check("after_abort_lat", 32'(lat), 32'd6);

      // DP_WIDTH=8 instance
      do_mult8(8'd255, 8'd255, 1'b0, lat);
      check("w8_255_x_255", 32'(product8), 32'd65025);
      check("w8_lat_uns", 32'(lat), 32'd9);
      do_mult8(8'h80, 8'h7F, 1'b1, lat);
      check("w8_m128_x_127", 32'(product8), 32'hC080);
      check("w8_lat_sgn", 32'(lat), 32'd9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
